// File: rtl/match_filter_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mfctrl_pkg                                                        |
// | Desc    : Shared types, info-word layout and command bits for the match    |
// |           filter controller.                                               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mfctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIS  = 2'd1,
    COEF = 2'd2,
    ENA  = 2'd3
  } state_t;

  localparam int LEN_MSB   = 31;
  localparam int LEN_LSB   = 24;
  localparam int VALID_BIT = 23;
  localparam int THR_MSB   = 22;
  localparam int THR_LSB   = 0;

  localparam int         NUM_COEF_WORDS = 12;
  localparam logic [7:0] MAX_LEN        = 8'd192;

  localparam int CMD_COMMIT_BIT  = 0;
  localparam int CMD_DISABLE_BIT = 1;

  function automatic logic len_ok(input logic [7:0] len);
    return (len != 8'd0) && (len <= MAX_LEN);
  endfunction

  // Rebuild the info word with the valid flag replaced.
  function automatic logic [31:0] set_valid(input logic [31:0] info, input logic v);
    return {info[LEN_MSB:LEN_LSB], v, info[THR_MSB:THR_LSB]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/match_filter_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : match_filter_ctrl_if                                             |
// | Desc    : Host setting bus, filter write port, match handshake and status. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface match_filter_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             strobe_in;
  logic [6:0]       addr_in;
  logic [31:0]      data_in;
  logic             strobe_wr;
  logic [6:0]       addr_wr;
  logic [31:0]      data_wr;
  logic             rxstrobe;
  logic             match;
  logic             ack;
  logic             busy;
  logic             loaded;
  logic             cfg_err;
  logic             match_event;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] supp_count;
  logic [31:0]      match_ts;

  modport master (
    output strobe_in, addr_in, data_in, rxstrobe, match,
    input  strobe_wr, addr_wr, data_wr, ack, busy, loaded, cfg_err,
           match_event, match_count, supp_count, match_ts
  );

  modport slave (
    input  strobe_in, addr_in, data_in, rxstrobe, match,
    output strobe_wr, addr_wr, data_wr, ack, busy, loaded, cfg_err,
           match_event, match_count, supp_count, match_ts
  );
endinterface
`default_nettype wire

// File: rtl/match_event_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : match_event_ctrl                                                 |
// | Desc    : Match/ack handshake, post-detection holdoff and event counters.  |
// |           MFCTRL_TIMESTAMP_EN adds a sample counter latched per event.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module match_event_ctrl #(
  parameter int HOLDOFF = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxstrobe,
  input  logic             match,
  input  logic             busy,
  input  logic             loaded,
  input  logic             clr_holdoff,
  output logic             ack,
  output logic             match_event,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] supp_count,
  output logic [31:0]      match_ts
);

  localparam int HO_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  logic             ack_q, ack_d;
  logic [1:0]       blank_q, blank_d;
  logic             event_q, event_d;
  logic [HO_W-1:0]  holdoff_q, holdoff_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic [CNT_W-1:0] supp_count_q, supp_count_d;
  logic             detect, report;

  // The filter needs two cycles after ack before its match flag is trustworthy.
  assign detect = match && !ack_q && (blank_q == 2'd0);
  assign report = detect && (holdoff_q == '0) && !busy && loaded;

  always_comb begin
    ack_d         = detect;
    event_d       = report;
    blank_d       = 2'd0;
    holdoff_d     = holdoff_q;
    match_count_d = match_count_q;
    supp_count_d  = supp_count_q;

    if (ack_q)                 blank_d = 2'd2;
    else if (blank_q != 2'd0)  blank_d = blank_q - 2'd1;

    if (clr_holdoff)                        holdoff_d = '0;
    else if (report)                        holdoff_d = HO_W'(HOLDOFF);
    else if (rxstrobe && holdoff_q != '0)   holdoff_d = holdoff_q - HO_W'(1);

    if (report && match_count_q != '1)             match_count_d = match_count_q + CNT_W'(1);
    if (detect && !report && supp_count_q != '1)   supp_count_d  = supp_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q         <= 1'b0;
      blank_q       <= 2'd0;
      event_q       <= 1'b0;
      holdoff_q     <= '0;
      match_count_q <= '0;
      supp_count_q  <= '0;
    end else begin
      ack_q         <= ack_d;
      blank_q       <= blank_d;
      event_q       <= event_d;
      holdoff_q     <= holdoff_d;
      match_count_q <= match_count_d;
      supp_count_q  <= supp_count_d;
    end
  end

  assign ack         = ack_q;
  assign match_event = event_q;
  assign match_count = match_count_q;
  assign supp_count  = supp_count_q;

`ifdef MFCTRL_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_cnt_d;
  logic [31:0] match_ts_q, match_ts_d;

  always_comb begin
    ts_cnt_d   = rxstrobe ? ts_cnt_q + 32'd1 : ts_cnt_q;
    match_ts_d = report ? ts_cnt_q : match_ts_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt_q   <= 32'd0;
      match_ts_q <= 32'd0;
    end else begin
      ts_cnt_q   <= ts_cnt_d;
      match_ts_q <= match_ts_d;
    end
  end

  assign match_ts = match_ts_q;
`else
  assign match_ts = 32'd0;
`endif

endmodule
`default_nettype wire

// File: rtl/match_filter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : match_filter_ctrl                                                |
// | Desc    : Shadowed coefficient/info store with atomic disable-load-enable  |
// |           reload of the correlator; MFCTRL_TIMESTAMP_EN enables match_ts.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module match_filter_ctrl
  import mfctrl_pkg::*;
#(
  parameter int COEF_BASE   = 50,
  parameter int SHADOW_BASE = 70,
  parameter int HOLDOFF     = 64,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  match_filter_ctrl_if.slave bus
);

  localparam int         NSHADOW   = NUM_COEF_WORDS + 1;
  localparam logic [6:0] INFO_ADDR = 7'(COEF_BASE + NUM_COEF_WORDS);
  localparam logic [6:0] CMD_ADDR  = 7'(SHADOW_BASE + NUM_COEF_WORDS + 1);

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic        dis_only_q, dis_only_d;
  logic [31:0] shadow_q [NSHADOW];
  logic [31:0] shadow_d [NSHADOW];
  logic        strobe_wr_q, strobe_wr_d;
  logic [6:0]  addr_wr_q, addr_wr_d;
  logic [31:0] data_wr_q, data_wr_d;
  logic        busy_q, busy_d;
  logic        loaded_q, loaded_d;
  logic        cfg_err_q, cfg_err_d;
  logic        clr_holdoff;
  logic        cmd_hit;
  logic [31:0] info_d;

  // Outgoing data comes from shadow_d so a same-cycle host write is not lost.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NSHADOW; i++) begin
      if (bus.strobe_in && bus.addr_in == 7'(SHADOW_BASE + i)) shadow_d[i] = bus.data_in;
    end
  end

  assign info_d  = shadow_d[NUM_COEF_WORDS];
  assign cmd_hit = bus.strobe_in && (bus.addr_in == CMD_ADDR);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    dis_only_d  = dis_only_q;
    strobe_wr_d = 1'b0;
    addr_wr_d   = addr_wr_q;
    data_wr_d   = data_wr_q;
    busy_d      = 1'b0;
    loaded_d    = loaded_q;
    cfg_err_d   = cfg_err_q;
    clr_holdoff = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_hit && (bus.data_in[CMD_DISABLE_BIT] ||
                        (bus.data_in[CMD_COMMIT_BIT] && len_ok(info_d[LEN_MSB:LEN_LSB])))) begin
          state_d     = DIS;
          dis_only_d  = bus.data_in[CMD_DISABLE_BIT];
          strobe_wr_d = 1'b1;
          addr_wr_d   = INFO_ADDR;
          data_wr_d   = set_valid(info_d, 1'b0);
          busy_d      = 1'b1;
          clr_holdoff = 1'b1;
        end else if (cmd_hit && bus.data_in[CMD_COMMIT_BIT]) begin
          cfg_err_d = 1'b1;
        end
      end
      DIS: begin
        loaded_d = 1'b0;
        if (dis_only_q) begin
          state_d = IDLE;
        end else begin
          state_d     = COEF;
          strobe_wr_d = 1'b1;
          addr_wr_d   = 7'(COEF_BASE);
          data_wr_d   = shadow_d[0];
          k_d         = 4'd1;
          busy_d      = 1'b1;
        end
      end
      COEF: begin
        strobe_wr_d = 1'b1;
        busy_d      = 1'b1;
        if (k_q == 4'(NUM_COEF_WORDS)) begin
          state_d   = ENA;
          addr_wr_d = INFO_ADDR;
          data_wr_d = set_valid(info_d, 1'b1);
        end else begin
          addr_wr_d = 7'(COEF_BASE) + 7'(k_q);
          data_wr_d = shadow_d[k_q];
          k_d       = k_q + 4'd1;
        end
      end
      ENA: begin
        state_d  = IDLE;
        loaded_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && cmd_hit) cfg_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= 4'd0;
      dis_only_q  <= 1'b0;
      strobe_wr_q <= 1'b0;
      addr_wr_q   <= 7'd0;
      data_wr_q   <= 32'd0;
      busy_q      <= 1'b0;
      loaded_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < NSHADOW; i++) shadow_q[i] <= 32'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      dis_only_q  <= dis_only_d;
      strobe_wr_q <= strobe_wr_d;
      addr_wr_q   <= addr_wr_d;
      data_wr_q   <= data_wr_d;
      busy_q      <= busy_d;
      loaded_q    <= loaded_d;
      cfg_err_q   <= cfg_err_d;
      shadow_q    <= shadow_d;
    end
  end

  assign bus.strobe_wr = strobe_wr_q;
  assign bus.addr_wr   = addr_wr_q;
  assign bus.data_wr   = data_wr_q;
  assign bus.busy      = busy_q;
  assign bus.loaded    = loaded_q;
  assign bus.cfg_err   = cfg_err_q;

  match_event_ctrl #(
    .HOLDOFF (HOLDOFF),
    .CNT_W   (CNT_W)
  ) u_event (
    .clk         (clk),
    .reset       (reset),
    .rxstrobe    (bus.rxstrobe),
    .match       (bus.match),
    .busy        (busy_q),
    .loaded      (loaded_q),
    .clr_holdoff (clr_holdoff),
    .ack         (bus.ack),
    .match_event (bus.match_event),
    .match_count (bus.match_count),
    .supp_count  (bus.supp_count),
    .match_ts    (bus.match_ts)
  );

endmodule
`default_nettype wire

// File: tb/tb_match_filter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_match_filter_ctrl                                             |
// | Desc    : Directed self-checking bench for match_filter_ctrl (HOLDOFF=4).  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_match_filter_ctrl;

  localparam int CNT_W = 16;
  localparam logic [31:0] INFO48 = 32'h3000_03E8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  match_filter_ctrl_if #(.CNT_W(CNT_W)) ifc ();

  match_filter_ctrl #(
    .COEF_BASE   (50),
    .SHADOW_BASE (70),
    .HOLDOFF     (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic host_write(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    ifc.strobe_in = 1'b1;
    ifc.addr_in   = a;
    ifc.data_in   = d;
    @(negedge clk);
    ifc.strobe_in = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_shadows(input logic [31:0] info);
    for (int k = 0; k < 12; k++) host_write(7'(70 + k), 32'hA000_0000 | 32'(k));
    host_write(7'd82, info);
  endtask

  task automatic pulse_rx(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ifc.rxstrobe = 1'b1;
      @(negedge clk); ifc.rxstrobe = 1'b0;
    end
  endtask

  // Counts filter writes from the current (first post-command) cycle onward.
  task automatic count_writes(input int ncyc, output int n);
    n = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (ifc.strobe_wr) n++;
      @(negedge clk);
    end
  endtask

  // Raises match like the filter does and drops it once ack is seen.
  task automatic do_match(output bit got_ack, output bit ev, output bit ack_twice);
    got_ack = 1'b0; ev = 1'b0; ack_twice = 1'b0;
    @(negedge clk);
    ifc.match = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifc.ack) begin
        got_ack = 1'b1;
        ev      = ifc.match_event;
        break;
      end
    end
    ifc.match = 1'b0;
    @(negedge clk);
    ack_twice = ifc.ack;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({ifc.strobe_wr, ifc.addr_wr, ifc.data_wr} !== 40'd0) begin
      errors++; $display("FAIL reset_wrport: got %0b/%0d/%h want 0", ifc.strobe_wr, ifc.addr_wr, ifc.data_wr);
    end
    checks++;
    if ({ifc.ack, ifc.busy, ifc.loaded, ifc.cfg_err, ifc.match_event} !== 5'd0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000",
                         {ifc.ack, ifc.busy, ifc.loaded, ifc.cfg_err, ifc.match_event});
    end
    checks++;
    if (ifc.match_count !== 16'd0 || ifc.supp_count !== 16'd0 || ifc.match_ts !== 32'd0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0", ifc.match_count, ifc.supp_count, ifc.match_ts);
    end
  endtask

  task automatic test_commit_order();
    logic [6:0]  ea;
    logic [31:0] ed;
    load_shadows(INFO48);
    host_write(7'd83, 32'd1);
    for (int c = 1; c <= 14; c++) begin
      if (c == 1)       begin ea = 7'd62; ed = INFO48; end
      else if (c == 14) begin ea = 7'd62; ed = 32'h3080_03E8; end
      else              begin ea = 7'(50 + c - 2); ed = 32'hA000_0000 | 32'(c - 2); end
      checks++;
      if (ifc.strobe_wr !== 1'b1 || ifc.busy !== 1'b1 || ifc.addr_wr !== ea || ifc.data_wr !== ed) begin
        errors++; $display("FAIL commit_c%0d: got stb=%b busy=%b %0d/%h want 1 1 %0d/%h",
                           c, ifc.strobe_wr, ifc.busy, ifc.addr_wr, ifc.data_wr, ea, ed);
      end
      @(negedge clk);
    end
    checks++;
    if (ifc.strobe_wr !== 1'b0 || ifc.busy !== 1'b0 || ifc.loaded !== 1'b1 || ifc.cfg_err !== 1'b0) begin
      errors++; $display("FAIL commit_c15: got stb=%b busy=%b loaded=%b err=%b want 0 0 1 0",
                         ifc.strobe_wr, ifc.busy, ifc.loaded, ifc.cfg_err);
    end
  endtask

  task automatic test_bad_length();
    int n;
    host_write(7'd82, 32'h0000_03E8);
    host_write(7'd83, 32'd1);
    count_writes(16, n);
    checks++;
    if (n !== 0 || ifc.cfg_err !== 1'b1 || ifc.loaded !== 1'b1) begin
      errors++; $display("FAIL len0: got writes=%0d err=%b loaded=%b want 0 1 1", n, ifc.cfg_err, ifc.loaded);
    end
    apply_reset();
    host_write(7'd82, 32'hC800_03E8);
    host_write(7'd83, 32'd1);
    count_writes(16, n);
    checks++;
    if (n !== 0 || ifc.cfg_err !== 1'b1 || ifc.loaded !== 1'b0) begin
      errors++; $display("FAIL len200: got writes=%0d err=%b loaded=%b want 0 1 0", n, ifc.cfg_err, ifc.loaded);
    end
  endtask

  task automatic test_len_boundary();
    int n;
    apply_reset();
    host_write(7'd82, 32'hC000_03E8);
    host_write(7'd83, 32'd1);
    count_writes(16, n);
    checks++;
    if (n !== 14 || ifc.cfg_err !== 1'b0 || ifc.loaded !== 1'b1) begin
      errors++; $display("FAIL len192: got writes=%0d err=%b loaded=%b want 14 0 1", n, ifc.cfg_err, ifc.loaded);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    apply_reset();
    load_shadows(INFO48);
    host_write(7'd83, 32'd1);
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      if (ifc.strobe_wr) n++;
      if (c == 5) begin ifc.strobe_in = 1'b1; ifc.addr_in = 7'd83; ifc.data_in = 32'd1; end
      if (c == 6) ifc.strobe_in = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (n !== 14 || ifc.cfg_err !== 1'b1 || ifc.loaded !== 1'b1) begin
      errors++; $display("FAIL busy_cmd: got writes=%0d err=%b loaded=%b want 14 1 1", n, ifc.cfg_err, ifc.loaded);
    end
  endtask

  task automatic test_match_holdoff();
    bit a, e, a2;
    do_match(a, e, a2);
    checks++;
    if ({a, e, a2} !== 3'b110 || ifc.match_count !== 16'd1 || ifc.supp_count !== 16'd0) begin
      errors++; $display("FAIL match1: got ack=%b ev=%b ack2=%b mc=%0d sc=%0d want 1 1 0 1 0",
                         a, e, a2, ifc.match_count, ifc.supp_count);
    end
    pulse_rx(2);
    do_match(a, e, a2);
    checks++;
    if ({a, e, a2} !== 3'b100 || ifc.match_count !== 16'd1 || ifc.supp_count !== 16'd1) begin
      errors++; $display("FAIL match_holdoff: got ack=%b ev=%b ack2=%b mc=%0d sc=%0d want 1 0 0 1 1",
                         a, e, a2, ifc.match_count, ifc.supp_count);
    end
    pulse_rx(4);
    do_match(a, e, a2);
    checks++;
    if ({a, e, a2} !== 3'b110 || ifc.match_count !== 16'd2 || ifc.supp_count !== 16'd1) begin
      errors++; $display("FAIL match_after: got ack=%b ev=%b ack2=%b mc=%0d sc=%0d want 1 1 0 2 1",
                         a, e, a2, ifc.match_count, ifc.supp_count);
    end
  endtask

  task automatic test_disable();
    bit a, e, a2;
    int n;
    host_write(7'd83, 32'd2);
    checks++;
    if (ifc.strobe_wr !== 1'b1 || ifc.busy !== 1'b1 || ifc.addr_wr !== 7'd62 || ifc.data_wr !== INFO48) begin
      errors++; $display("FAIL dis_write: got stb=%b busy=%b %0d/%h want 1 1 62/%h",
                         ifc.strobe_wr, ifc.busy, ifc.addr_wr, ifc.data_wr, INFO48);
    end
    @(negedge clk);
    checks++;
    if (ifc.strobe_wr !== 1'b0 || ifc.busy !== 1'b0 || ifc.loaded !== 1'b0) begin
      errors++; $display("FAIL dis_after: got stb=%b busy=%b loaded=%b want 0 0 0", ifc.strobe_wr, ifc.busy, ifc.loaded);
    end
    do_match(a, e, a2);
    checks++;
    if ({a, e} !== 2'b10 || ifc.match_count !== 16'd2 || ifc.supp_count !== 16'd2) begin
      errors++; $display("FAIL dis_match: got ack=%b ev=%b mc=%0d sc=%0d want 1 0 2 2",
                         a, e, ifc.match_count, ifc.supp_count);
    end
    host_write(7'd83, 32'd3);
    count_writes(18, n);
    checks++;
    if (n !== 1 || ifc.loaded !== 1'b0 || ifc.data_wr !== INFO48) begin
      errors++; $display("FAIL dis_wins: got writes=%0d loaded=%b data=%h want 1 0 %h", n, ifc.loaded, ifc.data_wr, INFO48);
    end
  endtask

  task automatic test_timestamp();
    bit a, e, a2;
    logic [31:0] exp_ts;
`ifdef MFCTRL_TIMESTAMP_EN
    exp_ts = 32'd100;
`else
    exp_ts = 32'd0;
`endif
    apply_reset();
    load_shadows(INFO48);
    host_write(7'd83, 32'd1);
    repeat (16) @(negedge clk);
    pulse_rx(100);
    do_match(a, e, a2);
    checks++;
    if (e !== 1'b1 || ifc.match_ts !== exp_ts) begin
      errors++; $display("FAIL timestamp: got ev=%b ts=%0d want 1 %0d", e, ifc.match_ts, exp_ts);
    end
  endtask

  initial begin
    ifc.strobe_in = 1'b0;
    ifc.addr_in   = 7'd0;
    ifc.data_in   = 32'd0;
    ifc.rxstrobe  = 1'b0;
    ifc.match     = 1'b0;
    test_reset();
    test_commit_order();
    test_bad_length();
    test_len_boundary();
    test_back_to_back();
    test_match_holdoff();
    test_disable();
    test_timestamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/match_filter_ctrl.md
Name: match_filter_ctrl

Overview:
- Configuration sequencer and event handler for the in-band correlator (match filter).
- Holds a shadow copy of the 12 coefficient words and the info word. On a host commit, it reloads the filter's setting registers atomically: disable, coefficients, then enable.
- Owns the filter's match/ack handshake and applies a sample-count holdoff after each detection.
- Sits between the host setting bus and the filter's write port; event outputs go to packet/status logic.

Parameters:
- COEF_BASE, 50, setting address of first filter coefficient word (12 words, COEF_BASE..COEF_BASE+11); info word at COEF_BASE+12.
- SHADOW_BASE, 70, host addresses: coefficient shadows SHADOW_BASE..+11, info shadow +12, command +13.
- HOLDOFF, 64, rxstrobe samples after a detection during which new matches are acked but not reported.
- CNT_W, 16, width of the match and suppressed counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- strobe_in  in  1  host setting-bus write strobe
- addr_in  in  7  host setting-bus address
- data_in  in  32  host setting-bus data
- strobe_wr  out  1  filter setting-bus write strobe
- addr_wr  out  7  filter setting-bus address
- data_wr  out  32  filter setting-bus data
- rxstrobe  in  1  sample strobe (same as filter)
- match  in  1  filter match flag (level, held until ack)
- ack  out  1  clears filter match
- busy  out  1  reload sequence in progress
- loaded  out  1  filter holds a valid committed config
- cfg_err  out  1  sticky: rejected commit or command while busy
- match_event  out  1  one-cycle pulse per reported detection
- match_count  out  CNT_W  reported detections, saturating
- supp_count  out  CNT_W  suppressed detections, saturating
- match_ts  out  32  sample timestamp of last reported detection

Behaviour:
- Reset: all outputs 0; shadows 0; FSM IDLE; holdoff counter 0.
- Shadow writes: strobe_in with addr_in in SHADOW_BASE..+12 updates that shadow in any state. They never reach the filter directly. Info layout: [31:24] length, [23] valid, [22:0] threshold.
- Command word (addr SHADOW_BASE+13):
  - bit0 = commit.
  - bit1 = disable.
  - Both set: disable wins.
- Command rejection:
  - Any command received while busy: ignored; cfg_err set.
  - Commit with shadow length 0 or >192: no writes; cfg_err set.
- FSM states: IDLE -> DIS -> COEF -> ENA -> IDLE.
  - DIS: one write, addr COEF_BASE+12, data = info shadow with bit23 forced 0.
  - COEF: 12 consecutive writes, addr COEF_BASE+k, data shadow[k], k = 0..11.
  - ENA: one write, addr COEF_BASE+12, data = info shadow with bit23 forced 1.
- Commit timing:
  - Command accepted at cycle 0; first strobe_wr at cycle 1.
  - Writes on cycles 1..14, one per cycle; busy high cycles 1..14.
  - loaded rises at cycle 15.
  - Coefficient data is sampled from shadows at the cycle it is written; shadow writes during busy take effect if not yet sent.
- Disable command (IDLE only): single DIS write at cycle 1; busy high cycle 1 only; loaded cleared at cycle 2.
- strobe_wr is low in all cycles not listed above; addr_wr/data_wr hold last value.
- Match handshake:
  - When match is seen high and ack is not already asserted, ack is driven high for exactly the next cycle.
  - After an ack pulse, match is ignored for 2 cycles (filter clear latency).
- Reported detection (holdoff counter == 0, not busy, loaded):
  - match_event pulses in the ack cycle.
  - match_count increments.
  - Holdoff counter loads HOLDOFF.
- Suppressed detection (holdoff counter != 0, busy, or !loaded): ack issued; no event; supp_count increments.
- Holdoff counter decrements on rxstrobe and stops at 0. A commit or disable zeroes it.
- Counters saturate at all-ones. They are cleared only by reset.
- Reset mid-sequence: FSM returns to IDLE immediately and loaded = 0. The filter may retain a partial config with valid = 0 if the DIS write occurred.

Optional Feature:
- MFCTRL_TIMESTAMP_EN defined:
  - 32-bit sample counter increments on rxstrobe and wraps at 2^32.
  - Its value is latched into match_ts on each match_event.
  - Counter and match_ts are reset to 0.
- MFCTRL_TIMESTAMP_EN not defined: match_ts tied to 0; no counter logic.

Decomposition:
- Package mfctrl_pkg:
  - FSM state encoding: IDLE, DIS, COEF, ENA.
  - Info field positions/widths (LEN_MSB/LSB, VALID_BIT, THR_MSB/LSB).
  - NUM_COEF_WORDS = 12, MAX_LEN = 192.
  - Command bit positions.
- Sub-module match_event_ctrl: ack generation, 2-cycle blanking, holdoff counter, counters, optional timestamp. The top module keeps the shadows and reload FSM.

Test Plan:
- Commit ordering: write shadows k -> 32'hA000_000k, info = {8'd48, 1'b0, 23'd1000}, commit -> cycle 1 write addr 62 data 0x300003E8; cycles 2..13 addr 50..61 data A000_0000..A000_000B; cycle 14 addr 62 data 0x308003E8; loaded = 1 at cycle 15.
- Bad length: info length 0 or 200, commit -> no strobe_wr, cfg_err = 1, loaded unchanged.
- Command while busy: commit, then commit again at cycle 5 -> exactly 14 writes total, cfg_err = 1.
- Match with holdoff: loaded, HOLDOFF = 4, match high -> ack one cycle, match_event pulse, match_count = 1. Re-match after 2 rxstrobes -> acked, supp_count = 1. Re-match after 4 more rxstrobes -> match_count = 2.
- Disable: disable command -> single write addr 62 with bit23 = 0, loaded = 0. Subsequent match -> acked, supp_count increments, no event.
- Timestamp (MFCTRL_TIMESTAMP_EN): 100 rxstrobes, then match -> match_ts = 100.
